// File: rtl/branch_predict_tournament.sv
// Tournament branch predictor: a local (per-PC history) predictor and a gshare
// global predictor, arbitrated per PC by a 2-bit chooser table. The prediction
// is looked up in F, carried down a small F->D->E->M pipeline, and every table
// is trained non-speculatively when the branch resolves in M.
module branch_predict_tournament #(
  parameter int BHT_DEPTH  = 10,
  parameter int LPHT_DEPTH = 6,
  parameter int GPHT_DEPTH = 8,
  parameter int CPHT_DEPTH = 8,
  parameter int MODE       = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flushD,
  input  logic             stallD,
  input  logic             flushE,
  input  logic             flushM,
  input  logic [31:0]      pcF,
  input  logic [31:0]      pcM,
  input  logic             branchD,
  input  logic             branchM,
  input  logic             actual_takeM,
  output logic             pred_takeD,
  output logic             correct,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int BHT_N  = 1 << BHT_DEPTH;
  localparam int LPHT_N = 1 << LPHT_DEPTH;
  localparam int GPHT_N = 1 << GPHT_DEPTH;
  localparam int CPHT_N = 1 << CPHT_DEPTH;

  // MODE 3 falls through to the tournament arm of the selector below.
  localparam logic [1:0] MODE_SEL    = 2'(MODE);
  localparam bit         USE_CHOOSER = (MODE_SEL == 2'd0) || (MODE_SEL == 2'd3);

  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
  localparam logic [1:0] CTR_WEAK_LOCAL = 2'b01;

  // 2-bit saturating counter step: up saturates at 11, down saturates at 00.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    logic [1:0] nxt;
    if (up) begin
      nxt = (ctr == 2'b11) ? 2'b11 : (ctr + 2'b01);
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : (ctr - 2'b01);
    end
    return nxt;
  endfunction

  // Prediction state
  logic [LPHT_DEPTH-1:0] r_bht  [BHT_N];
  logic [1:0]            r_lpht [LPHT_N];
  logic [1:0]            r_gpht [GPHT_N];
  logic [1:0]            r_cpht [CPHT_N];
  logic [GPHT_DEPTH-1:0] r_ghr;

  // Pipeline bits {pred, local, global}
  logic [2:0] r_pipe_d;
  logic [2:0] r_pipe_e;
  logic [2:0] r_pipe_m;

  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  // F-stage lookup
  logic [BHT_DEPTH-1:0]  w_bht_idx_f;
  logic [LPHT_DEPTH-1:0] w_lidx_f;
  logic [GPHT_DEPTH-1:0] w_gidx_f;
  logic [CPHT_DEPTH-1:0] w_cidx_f;
  logic                  w_local_f;
  logic                  w_global_f;
  logic                  w_use_g_f;
  logic                  w_pred_f;

  // M-stage indices, rebuilt from pcM with pre-edge histories
  logic [BHT_DEPTH-1:0]  w_bht_idx_m;
  logic [LPHT_DEPTH-1:0] w_lidx_m;
  logic [GPHT_DEPTH-1:0] w_gidx_m;
  logic [CPHT_DEPTH-1:0] w_cidx_m;
  logic                  w_pred_m;
  logic                  w_local_m;
  logic                  w_global_m;

  // PC bits outside every index field are intentionally ignored.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{pcF, pcM};

  assign w_bht_idx_f = pcF[BHT_DEPTH+1:2];
  assign w_lidx_f    = pcF[LPHT_DEPTH+1:2] ^ r_bht[w_bht_idx_f];
  assign w_gidx_f    = pcF[GPHT_DEPTH+1:2] ^ r_ghr;
  assign w_cidx_f    = pcF[CPHT_DEPTH+1:2];
  assign w_local_f   = r_lpht[w_lidx_f][1];
  assign w_global_f  = r_gpht[w_gidx_f][1];
  assign w_use_g_f   = r_cpht[w_cidx_f][1];

  assign w_bht_idx_m = pcM[BHT_DEPTH+1:2];
  assign w_lidx_m    = pcM[LPHT_DEPTH+1:2] ^ r_bht[w_bht_idx_m];
  assign w_gidx_m    = pcM[GPHT_DEPTH+1:2] ^ r_ghr;
  assign w_cidx_m    = pcM[CPHT_DEPTH+1:2];
  assign w_pred_m    = r_pipe_m[2];
  assign w_local_m   = r_pipe_m[1];
  assign w_global_m  = r_pipe_m[0];

  // Select the F-stage prediction source according to MODE.
  always_comb begin
    w_pred_f = w_local_f;
    case (MODE_SEL)
      2'd1:    w_pred_f = w_local_f;
      2'd2:    w_pred_f = w_global_f;
      default: w_pred_f = w_use_g_f ? w_global_f : w_local_f;
    endcase
  end

  // Reset or train the pattern tables, chooser and histories at M resolution.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++)  r_bht[i]  <= '0;
      for (int i = 0; i < LPHT_N; i++) r_lpht[i] <= CTR_WEAK_TAKEN;
      for (int i = 0; i < GPHT_N; i++) r_gpht[i] <= CTR_WEAK_TAKEN;
      for (int i = 0; i < CPHT_N; i++) r_cpht[i] <= CTR_WEAK_LOCAL;
      r_ghr <= '0;
    end else if (branchM) begin
      r_lpht[w_lidx_m] <= ctr_step(r_lpht[w_lidx_m], actual_takeM);
      r_gpht[w_gidx_m] <= ctr_step(r_gpht[w_gidx_m], actual_takeM);
      if (USE_CHOOSER && (w_local_m != w_global_m)) begin
        r_cpht[w_cidx_m] <= ctr_step(r_cpht[w_cidx_m], w_global_m == actual_takeM);
      end
      r_bht[w_bht_idx_m] <= {r_bht[w_bht_idx_m][LPHT_DEPTH-2:0], actual_takeM};
      r_ghr              <= {r_ghr[GPHT_DEPTH-2:0], actual_takeM};
    end
  end

  // Advance prediction bits F->D->E->M; a clear wins over the D-stage hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_d <= 3'b000;
      r_pipe_e <= 3'b000;
      r_pipe_m <= 3'b000;
    end else begin
      if (flushD) begin
        r_pipe_d <= 3'b000;
      end else if (!stallD) begin
        r_pipe_d <= {w_pred_f, w_local_f, w_global_f};
      end
      r_pipe_e <= flushE ? 3'b000 : r_pipe_d;
      r_pipe_m <= flushM ? 3'b000 : r_pipe_e;
    end
  end

  // Count resolved and mispredicted branches; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (branchM) begin
      r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_pred_m != actual_takeM) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign pred_takeD  = branchD & r_pipe_d[2];
  assign correct     = (actual_takeM == (branchM & w_pred_m));
  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule
